// File: rtl/encoder_8b10b_rd.sv
// Multi-lane 8b/10b encoder with running-disparity selection, A7 handling,
// K-code validation and K28.5 idle insertion. Registered outputs, one-cycle latency.
module encoder_8b10b_rd #(
    parameter int LANES       = 2,
    parameter int IDLE_INSERT = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enb,
    input  logic                  valid_in,
    input  logic [8*LANES-1:0]    entradas,
    input  logic [LANES-1:0]      k_in,
    output logic [10*LANES-1:0]   salidas,
    output logic                  valid_out,
    output logic [LANES-1:0]      k_err,
    output logic                  rd_out
);

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef struct packed {
        logic [9:0] code;
        logic       rd;
        logic       kerr;
    } lane_t;

    // 5b/6b codes for RD-, written in transmission order a..i (leftmost = a)
    function automatic logic [5:0] tbl6(input logic [4:0] x);
        case (x)
            5'd0:    tbl6 = 6'b100111;
            5'd1:    tbl6 = 6'b011101;
            5'd2:    tbl6 = 6'b101101;
            5'd3:    tbl6 = 6'b110001;
            5'd4:    tbl6 = 6'b110101;
            5'd5:    tbl6 = 6'b101001;
            5'd6:    tbl6 = 6'b011001;
            5'd7:    tbl6 = 6'b111000;
            5'd8:    tbl6 = 6'b111001;
            5'd9:    tbl6 = 6'b100101;
            5'd10:   tbl6 = 6'b010101;
            5'd11:   tbl6 = 6'b110100;
            5'd12:   tbl6 = 6'b001101;
            5'd13:   tbl6 = 6'b101100;
            5'd14:   tbl6 = 6'b011100;
            5'd15:   tbl6 = 6'b010111;
            5'd16:   tbl6 = 6'b011011;
            5'd17:   tbl6 = 6'b100011;
            5'd18:   tbl6 = 6'b010011;
            5'd19:   tbl6 = 6'b110010;
            5'd20:   tbl6 = 6'b001011;
            5'd21:   tbl6 = 6'b101010;
            5'd22:   tbl6 = 6'b011010;
            5'd23:   tbl6 = 6'b111010;
            5'd24:   tbl6 = 6'b110011;
            5'd25:   tbl6 = 6'b100110;
            5'd26:   tbl6 = 6'b010110;
            5'd27:   tbl6 = 6'b110110;
            5'd28:   tbl6 = 6'b001110;
            5'd29:   tbl6 = 6'b101110;
            5'd30:   tbl6 = 6'b011110;
            default: tbl6 = 6'b101011;
        endcase
    endfunction

    // 3b/4b data codes for RD-, order f..j; y=7 is the primary P7 form
    function automatic logic [3:0] tbl4(input logic [2:0] y);
        case (y)
            3'd0:    tbl4 = 4'b1011;
            3'd1:    tbl4 = 4'b1001;
            3'd2:    tbl4 = 4'b0101;
            3'd3:    tbl4 = 4'b1100;
            3'd4:    tbl4 = 4'b1101;
            3'd5:    tbl4 = 4'b1010;
            3'd6:    tbl4 = 4'b0110;
            default: tbl4 = 4'b1110;
        endcase
    endfunction

    function automatic logic [5:0] rev6(input logic [5:0] v);
        for (int i = 0; i < 6; i++) rev6[i] = v[5-i];
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] v);
        for (int i = 0; i < 4; i++) rev4[i] = v[3-i];
    endfunction

    function automatic lane_t encode_lane(input logic [7:0] d, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       is_k28, kc, a7, rd6, rd4;
        logic [5:0] c6;
        logic [3:0] c4;
        lane_t      r;
        x      = d[4:0];
        y      = d[7:5];
        is_k28 = (x == 5'd28);
        kc     = k && (is_k28 || d == 8'hF7 || d == 8'hFB || d == 8'hFD || d == 8'hFE);

        c6 = (kc && is_k28) ? 6'b001111 : tbl6(x);
        if (x == 5'd7) begin
            c6  = rd ? 6'b000111 : 6'b111000;
            rd6 = rd;
        end else if ($countones(c6) != 3) begin
            c6  = rd ? ~c6 : c6;
            rd6 = ~rd;
        end else begin
            rd6 = rd;
        end

        // A7 avoids a run of five equal bits across the 6b/4b boundary
        a7 = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                 : (x == 5'd17 || x == 5'd18 || x == 5'd20);
        c4 = (y == 3'd7 && (kc || a7)) ? 4'b0111 : tbl4(y);
        if (y == 3'd3) begin
            c4  = rd6 ? 4'b0011 : 4'b1100;
            rd4 = rd6;
        end else if ($countones(c4) != 2) begin
            c4  = rd6 ? ~c4 : c4;
            rd4 = ~rd6;
        end else begin
            rd4 = rd6;
        end
        if (kc && is_k28 && !rd6 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
            c4 = ~c4;

        r.code = {rev4(c4), rev6(c6)};
        r.rd   = rd4;
        r.kerr = k && !kc;
        return r;
    endfunction

    logic [10*LANES-1:0] code_next;
    logic [LANES-1:0]    kerr_next;
    logic                rd_next;
    logic                rd_chain;
    lane_t               lane_res;

    // RD ripples lane 0 -> LANES-1; idle cycles encode K28.5 on every lane
    always_comb begin
        code_next = '0;
        kerr_next = '0;
        lane_res  = '0;
        rd_chain  = rd_out;
        for (int l = 0; l < LANES; l++) begin
            lane_res = encode_lane(valid_in ? entradas[8*l +: 8] : K28_5,
                                   valid_in ? k_in[l] : 1'b1, rd_chain);
            code_next[10*l +: 10] = lane_res.code;
            kerr_next[l]          = lane_res.kerr;
            rd_chain              = lane_res.rd;
        end
        rd_next = rd_chain;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            salidas   <= '0;
            valid_out <= 1'b0;
            k_err     <= '0;
            rd_out    <= 1'b0;
        end else if (enb) begin
            valid_out <= valid_in;
            if (valid_in || IDLE_INSERT != 0) begin
                salidas <= code_next;
                k_err   <= valid_in ? kerr_next : '0;
                rd_out  <= rd_next;
            end else begin
                k_err <= '0;
            end
        end
    end

endmodule

// File: tb/tb_encoder_8b10b_rd.sv
// Directed bench for encoder_8b10b_rd: three instances (1 lane, 2 lanes, 1 lane
// without idle insertion) checked against hand-derived codes via a scoreboard queue.
module tb_encoder_8b10b_rd;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        enb = 1'b1;
    logic        valid_in = 1'b0;
    logic [7:0]  e1 = '0;
    logic [0:0]  k1 = '0;
    logic [15:0] e2 = '0;
    logic [1:0]  k2 = '0;

    logic [9:0]  s1, s3;
    logic [19:0] s2;
    logic        v1, v2, v3, r1, r2, r3;
    logic [0:0]  ke1, ke3;
    logic [1:0]  ke2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [9:0] s1;  logic r1; logic       ke1;
        logic [19:0] s2; logic r2; logic [1:0] ke2;
        logic [9:0] s3;  logic r3; logic       ke3;
        logic       v;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    encoder_8b10b_rd #(.LANES(1), .IDLE_INSERT(1)) u1 (
        .clk(clk), .reset_L(reset_L), .enb(enb), .valid_in(valid_in),
        .entradas(e1), .k_in(k1), .salidas(s1), .valid_out(v1), .k_err(ke1), .rd_out(r1));

    encoder_8b10b_rd #(.LANES(2), .IDLE_INSERT(1)) u2 (
        .clk(clk), .reset_L(reset_L), .enb(enb), .valid_in(valid_in),
        .entradas(e2), .k_in(k2), .salidas(s2), .valid_out(v2), .k_err(ke2), .rd_out(r2));

    encoder_8b10b_rd #(.LANES(1), .IDLE_INSERT(0)) u3 (
        .clk(clk), .reset_L(reset_L), .enb(enb), .valid_in(valid_in),
        .entradas(e1), .k_in(k1), .salidas(s3), .valid_out(v3), .k_err(ke3), .rd_out(r3));

    function automatic exp_t mk(string tag,
                                logic [9:0] xs1, logic xr1, logic xke1,
                                logic [19:0] xs2, logic xr2, logic [1:0] xke2,
                                logic [9:0] xs3, logic xr3, logic xke3, logic xv);
        exp_t e;
        e.tag = tag;
        e.s1 = xs1; e.r1 = xr1; e.ke1 = xke1;
        e.s2 = xs2; e.r2 = xr2; e.ke2 = xke2;
        e.s3 = xs3; e.r3 = xr3; e.ke3 = xke3;
        e.v  = xv;
        return e;
    endfunction

    task automatic chk(string tag, string field, logic [19:0] obs, logic [19:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "s1",  20'(s1),  20'(e.s1));
        chk(e.tag, "rd1", 20'(r1),  20'(e.r1));
        chk(e.tag, "ke1", 20'(ke1), 20'(e.ke1));
        chk(e.tag, "v1",  20'(v1),  20'(e.v));
        chk(e.tag, "s2",  s2,       e.s2);
        chk(e.tag, "rd2", 20'(r2),  20'(e.r2));
        chk(e.tag, "ke2", 20'(ke2), 20'(e.ke2));
        chk(e.tag, "v2",  20'(v2),  20'(e.v));
        chk(e.tag, "s3",  20'(s3),  20'(e.s3));
        chk(e.tag, "rd3", 20'(r3),  20'(e.r3));
        chk(e.tag, "ke3", 20'(ke3), 20'(e.ke3));
        chk(e.tag, "v3",  20'(v3),  20'(e.v));
    endtask

    task automatic applyStimulus(logic rl, logic en, logic vi,
                                 logic [7:0] d1, logic kk1, logic [15:0] d2, logic [1:0] kk2,
                                 exp_t e);
        @(negedge clk);
        reset_L  = rl;
        enb      = en;
        valid_in = vi;
        e1       = d1;
        k1       = kk1;
        e2       = d2;
        k2       = kk2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        applyStimulus(0, 1, 1, 8'h00, 0, 16'h0000, 2'b00,
            mk("reset", 10'h000, 0, 0, 20'h00000, 0, 2'b00, 10'h000, 0, 0, 0));
        applyStimulus(1, 1, 1, 8'h00, 0, 16'hBCBC, 2'b11,
            mk("d0_k285x2", 10'h0B9, 0, 0, 20'hA0D7C, 0, 2'b00, 10'h0B9, 0, 0, 1));
        applyStimulus(1, 1, 1, 8'hBC, 1, 16'hB5B5, 2'b00,
            mk("k285_rdm_d215", 10'h17C, 1, 0, 20'h55555, 0, 2'b00, 10'h17C, 1, 0, 1));
        applyStimulus(1, 1, 1, 8'hBC, 1, 16'hF1F1, 2'b00,
            mk("k285_rdp_d177", 10'h283, 0, 0, 20'h8C7B1, 0, 2'b00, 10'h283, 0, 0, 1));
        applyStimulus(1, 1, 1, 8'h00, 1, 16'h00FB, 2'b11,
            mk("kerr_k277", 10'h0B9, 0, 1, 20'h2E45B, 0, 2'b10, 10'h0B9, 0, 1, 1));
        applyStimulus(1, 1, 1, 8'hF1, 0, 16'h0000, 2'b00,
            mk("d177_a7", 10'h3B1, 1, 0, 20'h2E4B9, 0, 2'b00, 10'h3B1, 1, 0, 1));
        applyStimulus(1, 1, 0, 8'h00, 0, 16'h0000, 2'b00,
            mk("idle1", 10'h283, 0, 0, 20'hA0D7C, 0, 2'b00, 10'h3B1, 1, 0, 0));
        applyStimulus(1, 1, 0, 8'h00, 0, 16'h0000, 2'b00,
            mk("idle2", 10'h17C, 1, 0, 20'hA0D7C, 0, 2'b00, 10'h3B1, 1, 0, 0));
        applyStimulus(1, 0, 1, 8'h00, 0, 16'h0000, 2'b00,
            mk("enb_freeze", 10'h17C, 1, 0, 20'hA0D7C, 0, 2'b00, 10'h3B1, 1, 0, 0));
        applyStimulus(1, 1, 0, 8'h00, 0, 16'h0000, 2'b00,
            mk("idle3", 10'h283, 0, 0, 20'hA0D7C, 0, 2'b00, 10'h3B1, 1, 0, 0));
        applyStimulus(1, 1, 1, 8'hF1, 0, 16'h00BC, 2'b01,
            mk("mixed_chain", 10'h3B1, 1, 0, 20'hD197C, 1, 2'b00, 10'h231, 0, 0, 1));
        applyStimulus(1, 1, 1, 8'hF1, 0, 16'h0000, 2'b00,
            mk("d177_p7_rdp", 10'h231, 0, 0, 20'hD1B46, 1, 2'b00, 10'h3B1, 1, 0, 1));
        applyStimulus(0, 1, 1, 8'hBC, 1, 16'hBCBC, 2'b11,
            mk("reset_mid", 10'h000, 0, 0, 20'h00000, 0, 2'b00, 10'h000, 0, 0, 0));
        applyStimulus(1, 1, 1, 8'h00, 0, 16'h0000, 2'b00,
            mk("after_reset", 10'h0B9, 0, 0, 20'h2E4B9, 0, 2'b00, 10'h0B9, 0, 0, 1));
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
